// File: rtl/mem_ctrl.sv
// Byte-serial RAM port controller shared by instruction fetch and load/store.
// Arbitrates fairly on ties, sequences 1..4 byte cycles, assembles reads little-endian.
module mem_ctrl #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_done,
  output logic [31:0]       if_data,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [1:0]        mem_len,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_wdata,
  output logic              mem_done,
  output logic [31:0]       mem_rdata,
  output logic [ADDR_W-1:0] ram_a,
  output logic              ram_wr,
  output logic [7:0]        ram_dout,
  input  logic [7:0]        ram_din,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

  state_t      state, state_nx;
  logic        owner;       // 1 = MEM owns the current transaction
  logic        last_grant;  // 1 = MEM was granted last
  logic [2:0]  idx, n;
  logic [31:0] wdata, rbuf, asm_word;
  logic [1:0]  cap_sel;
  logic        grant_if, grant_mem;

  // On a tie the requester that did not win last time gets the port.
  assign grant_mem = mem_req && (!if_req || !last_grant);
  assign grant_if  = if_req && !grant_mem;

  // The byte arriving this cycle belongs to the address presented one cycle earlier.
  assign cap_sel = idx[1:0] - 2'd1;
  always_comb begin
    asm_word = rbuf;
    asm_word[{cap_sel, 3'b000} +: 8] = ram_din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    busy     = (state != IDLE);
    ram_wr   = 1'b0;
    ram_dout = 8'h00;
    if_done  = 1'b0;
    mem_done = 1'b0;
    case (state)
      IDLE: begin
        if (grant_mem)     state_nx = mem_we ? WR : RD;
        else if (grant_if) state_nx = RD;
      end
      RD: if (idx == n) state_nx = DONE;
      WR: begin
        ram_wr   = 1'b1;
        ram_dout = wdata[{idx[1:0], 3'b000} +: 8];
        if (idx == n - 3'd1) state_nx = DONE;
      end
      DONE: begin
        if_done  = !owner;
        mem_done = owner;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner      <= 1'b0;
      last_grant <= 1'b0;
      idx        <= '0;
      n          <= '0;
      ram_a      <= '0;
      wdata      <= '0;
      rbuf       <= '0;
      if_data    <= '0;
      mem_rdata  <= '0;
    end else begin
      case (state)
        IDLE: if (grant_mem || grant_if) begin
          owner      <= grant_mem;
          last_grant <= grant_mem;
          idx        <= '0;
          ram_a      <= grant_mem ? mem_addr : if_addr;
          n          <= grant_mem ? {1'b0, mem_len} + 3'd1 : 3'd4;
          wdata      <= mem_wdata;
          rbuf       <= '0;
        end
        RD: begin
          idx <= idx + 3'd1;
          if (idx < n - 3'd1) ram_a <= ram_a + ADDR_W'(1);
          if (idx != 3'd0) rbuf <= asm_word;
          if (idx == n) begin
            if (owner) mem_rdata <= asm_word;
            else       if_data   <= asm_word;
          end
        end
        WR: begin
          idx <= idx + 3'd1;
          if (idx < n - 3'd1) ram_a <= ram_a + ADDR_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: byte RAM model, per-requester scoreboard queues fed from a
// byte-level reference memory, directed timing checks plus randomized traffic.
module tb_mem_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, mem_req, mem_we;
  logic [1:0]  mem_len;
  logic [31:0] if_addr, mem_addr, mem_wdata;
  logic        if_done, mem_done, ram_wr, busy;
  logic [31:0] if_data, mem_rdata, ram_a;
  logic [7:0]  ram_dout, ram_din;

  always #5 clk = ~clk;

  mem_ctrl #(.ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
    .mem_req(mem_req), .mem_we(mem_we), .mem_len(mem_len), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_done(mem_done), .mem_rdata(mem_rdata),
    .ram_a(ram_a), .ram_wr(ram_wr), .ram_dout(ram_dout), .ram_din(ram_din),
    .busy(busy)
  );

  typedef struct packed {logic we; logic [31:0] data;} exp_t;

  logic [7:0]  ram   [logic [31:0]];
  logic [7:0]  model [logic [31:0]];
  logic [31:0] if_q[$];
  exp_t        mem_q[$];
  int          done_log[$];
  int          errors = 0;
  int          checks = 0;
  bit          prev_done = 1'b0;

  function automatic logic [7:0] init_byte(input logic [31:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction
  function automatic logic [7:0] ram_rd(input logic [31:0] a);
    return ram.exists(a) ? ram[a] : init_byte(a);
  endfunction
  function automatic logic [7:0] model_rd(input logic [31:0] a);
    return model.exists(a) ? model[a] : init_byte(a);
  endfunction
  function automatic logic [31:0] model_word(input logic [31:0] a, input int nb);
    logic [31:0] w = '0;
    for (int k = 0; k < nb; k++) w[8*k +: 8] = model_rd(a + 32'(k));
    return w;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_if(input logic [31:0] a);
    if_q.push_back(model_word(a, 4));
  endtask
  task automatic push_mem(input bit we, input logic [1:0] len, input logic [31:0] a,
                          input logic [31:0] wd);
    exp_t e;
    e.we = we;
    e.data = '0;
    if (we) for (int k = 0; k <= int'(len); k++) model[a + 32'(k)] = wd[8*k +: 8];
    else    e.data = model_word(a, int'(len) + 1);
    mem_q.push_back(e);
  endtask

  // Byte RAM: read data valid the cycle after the address.
  initial forever begin
    @(posedge clk);
    if (ram_wr) ram[ram_a] = ram_dout;
    ram_din <= ram_rd(ram_a);
  end

  // Monitor: pop and compare on every completion pulse.
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (rst) prev_done = 1'b0;
    else begin
      if (prev_done) chk("idle_after_done", 32'(busy), 32'd0);
      prev_done = if_done | mem_done;
      if (if_done) begin
        done_log.push_back(0);
        if (if_q.size() == 0) chk("if_unexpected_done", 32'(if_done), 32'd0);
        else chk("if_data", if_data, if_q.pop_front());
      end
      if (mem_done) begin
        done_log.push_back(1);
        if (mem_q.size() == 0) chk("mem_unexpected_done", 32'(mem_done), 32'd0);
        else begin
          e = mem_q.pop_front();
          if (!e.we) chk("mem_rdata", mem_rdata, e.data);
        end
      end
    end
  end

  // Directed transaction from an idle controller with cycle-exact checks.
  task automatic dir_txn(input bit is_if, input bit we, input logic [1:0] len,
                         input logic [31:0] addr, input logic [31:0] wdata);
    int n    = is_if ? 4 : int'(len) + 1;
    int last = we ? n + 1 : n + 2;
    if (is_if) push_if(addr); else push_mem(we, len, addr, wdata);
    @(posedge clk); #1;
    if (is_if) begin if_req = 1'b1; if_addr = addr; end
    else begin
      mem_req = 1'b1; mem_we = we; mem_len = len; mem_addr = addr; mem_wdata = wdata;
    end
    @(posedge clk);
    for (int c = 1; c <= last; c++) begin
      @(negedge clk);
      if (c <= n) chk("ram_a", ram_a, addr + 32'(c - 1));
      if (we && c <= n) begin
        chk("ram_wr", 32'(ram_wr), 32'd1);
        chk("ram_dout", 32'(ram_dout), 32'(wdata[8*(c-1) +: 8]));
      end else chk("ram_wr_low", 32'(ram_wr), 32'd0);
      chk(is_if ? "if_done_timing" : "mem_done_timing",
          32'(is_if ? if_done : mem_done), 32'(c == last));
      chk("other_done_low", 32'(is_if ? mem_done : if_done), 32'd0);
    end
    @(posedge clk); #1;
    if (is_if) if_req = 1'b0; else mem_req = 1'b0;
  endtask

  task automatic wait_done(input bit is_mem);
    bit ok = 1'b0;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge clk);
      if (is_mem ? mem_done : if_done) ok = 1'b1;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL done_timeout: requester %0d got no done within 60 cycles", is_mem);
    end
  endtask

  task automatic if_rand();
    logic [31:0] a = 32'h8000_0000 | 32'($urandom_range(0, 255));
    push_if(a);
    @(posedge clk); #1;
    if_req = 1'b1; if_addr = a;
    wait_done(1'b0);
    @(posedge clk); #1;
    if_req = 1'b0; if_addr = $urandom;
    repeat ($urandom_range(0, 3)) @(posedge clk);
  endtask

  task automatic mem_rand();
    bit          we  = 1'($urandom_range(0, 1));
    logic [1:0]  len = 2'($urandom_range(0, 3));
    logic [31:0] a   = 32'h1000 + 32'($urandom_range(0, 252));
    logic [31:0] wd  = $urandom;
    push_mem(we, len, a, wd);
    @(posedge clk); #1;
    mem_req = 1'b1; mem_we = we; mem_len = len; mem_addr = a; mem_wdata = wd;
    wait_done(1'b1);
    @(posedge clk); #1;
    mem_req = 1'b0; mem_wdata = $urandom; mem_addr = $urandom;
    repeat ($urandom_range(0, 3)) @(posedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; if_req = 1'b0; mem_req = 1'b0; mem_we = 1'b0; mem_len = 2'd0;
    if_addr = '0; mem_addr = '0; mem_wdata = '0;
    repeat (3) @(posedge clk); #1;
    chk("rst_ram_a", ram_a, 32'd0);
    chk("rst_ram_wr", 32'(ram_wr), 32'd0);
    chk("rst_ram_dout", 32'(ram_dout), 32'd0);
    chk("rst_if_done", 32'(if_done), 32'd0);
    chk("rst_if_data", if_data, 32'd0);
    chk("rst_mem_done", 32'(mem_done), 32'd0);
    chk("rst_mem_rdata", mem_rdata, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;

    // Fetch of a known word.
    ram[32'h100] = 8'h11; ram[32'h101] = 8'h22; ram[32'h102] = 8'h33; ram[32'h103] = 8'h44;
    model[32'h100] = 8'h11; model[32'h101] = 8'h22; model[32'h102] = 8'h33; model[32'h103] = 8'h44;
    dir_txn(1'b1, 1'b0, 2'd0, 32'h100, 32'd0);
    chk("fetch_word", if_data, 32'h4433_2211);

    // Two-byte store must not touch the following byte.
    dir_txn(1'b0, 1'b1, 2'd1, 32'h20, 32'hAABB_CCDD);
    chk("store_b0", 32'(ram_rd(32'h20)), 32'hDD);
    chk("store_b1", 32'(ram_rd(32'h21)), 32'hCC);
    chk("store_b2_untouched", 32'(ram_rd(32'h22)), 32'(init_byte(32'h22)));

    // Single-byte load zero-extends.
    ram[32'h7] = 8'hF0; model[32'h7] = 8'hF0;
    dir_txn(1'b0, 1'b0, 2'd0, 32'h7, 32'd0);
    chk("load_zext", mem_rdata, 32'h0000_00F0);

    // Address wrap at the top of the space.
    dir_txn(1'b1, 1'b0, 2'd0, 32'hFFFF_FFFE, 32'd0);

    // Reset in the middle of a four-byte store.
    @(posedge clk); #1;
    mem_req = 1'b1; mem_we = 1'b1; mem_len = 2'd3; mem_addr = 32'h40; mem_wdata = 32'h0102_0304;
    @(posedge clk);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_ram_wr", 32'(ram_wr), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_mem_done", 32'(mem_done), 32'd0);
    mem_req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (8) begin
      @(negedge clk);
      chk("no_done_after_rst", 32'(mem_done), 32'd0);
    end
    dir_txn(1'b0, 1'b1, 2'd3, 32'h40, 32'h0102_0304);
    dir_txn(1'b0, 1'b0, 2'd3, 32'h40, 32'd0);
    chk("reissued_store_readback", mem_rdata, 32'h0102_0304);

    // Both requesters held from reset: grants alternate starting with MEM.
    @(posedge clk); #1;
    rst = 1'b1;
    if_req = 1'b1; if_addr = 32'h8000_0040;
    mem_req = 1'b1; mem_we = 1'b0; mem_len = 2'd3; mem_addr = 32'h1010;
    push_if(32'h8000_0040); push_if(32'h8000_0040);
    push_mem(1'b0, 2'd3, 32'h1010, 32'd0); push_mem(1'b0, 2'd3, 32'h1010, 32'd0);
    done_log.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk); #1;
      if (done_log.size() >= 4) break;
    end
    @(posedge clk); #1;
    if_req = 1'b0; mem_req = 1'b0;
    repeat (12) @(posedge clk);
    chk("contention_done_count", 32'(done_log.size()), 32'd4);
    for (int k = 0; k < 4; k++)
      if (k < done_log.size()) chk("grant_order", 32'(done_log[k]), 32'((k % 2) == 0));

    // Randomized concurrent traffic.
    fork
      begin for (int i = 0; i < 15; i++) if_rand(); end
      begin for (int i = 0; i < 25; i++) mem_rand(); end
    join
    repeat (4) @(posedge clk);

    for (int a = 32'h1000; a < 32'h1100; a++)
      chk("ram_final", 32'(ram_rd(32'(a))), 32'(model_rd(32'(a))));
    chk("if_q_drained", 32'(if_q.size()), 32'd0);
    chk("mem_q_drained", 32'(mem_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mem_ctrl.md
# mem_ctrl

Memory controller that shares the single byte-wide RAM port between the instruction-fetch requester (IF) and the load/store requester (MEM stage). It arbitrates between the two, then sequences each 1–4-byte access as consecutive byte cycles, assembling read words little-endian. It sits between the pipeline front/back ends and the RAM, and is the only block that drives RAM address and write strobes.

## Interface
- ADDR_W, 32, RAM/requester address width; address arithmetic wraps modulo 2^ADDR_W.
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- if_req  in  1  IF request; level, held until if_done.
- if_addr  in  ADDR_W  IF word address (byte address of byte 0).
- if_done  out  1  one-cycle pulse; if_data valid in the same cycle.
- if_data  out  32  fetched word, byte0 in [7:0].
- mem_req  in  1  MEM request; level, held until mem_done.
- mem_we  in  1  1 = store, 0 = load.
- mem_len  in  2  byte count minus 1 (0..3 → 1..4 bytes).
- mem_addr  in  ADDR_W  byte address of first byte.
- mem_wdata  in  32  store data, byte k in [8k+7:8k].
- mem_done  out  1  one-cycle pulse; mem_rdata valid in the same cycle for loads.
- mem_rdata  out  32  load data, zero-extended (bytes not read are 0).
- ram_a  out  ADDR_W  RAM byte address.
- ram_wr  out  1  RAM write strobe.
- ram_dout  out  8  RAM write byte.
- ram_din  in  8  RAM read byte; valid the cycle after ram_a is presented.
- busy  out  1  high in any state other than IDLE.

## Operation
- States: IDLE, RD, WR, DONE. Registers: state, owner (IF/MEM), last_grant, idx[2:0], len N (1..4), base address, write data, read-assembly buffer.
- IDLE: if exactly one req high, grant it. If both are high, grant the requester not equal to last_grant. On grant, latch address, N (IF: always 4; MEM: mem_len+1), mem_we and mem_wdata; set last_grant; go to RD (IF, or MEM with we=0) or WR (MEM with we=1). Set idx=0, ram_a=base.
- RD: cycle k (k=0..N-1 from entry) presents ram_a=base+k. In cycles k=1..N, ram_din is the byte for address base+k-1 and is captured into buffer byte k-1. After the capture of byte N-1, go to DONE.
- WR: cycle k (k=0..N-1) drives ram_a=base+k, ram_dout=wdata byte k, ram_wr=1. After cycle N-1, go to DONE with ram_wr=0.
- DONE: exactly one cycle. The owner's done is high and its data output is valid. New requests are not sampled; next state is IDLE.
- if_data/mem_rdata hold their last value until the next completion for that requester.
- Requests are not pre-emptable. Dropping req mid-transaction does not abort it, and done still pulses. Input changes after grant are ignored.
- Address base+k wraps modulo 2^ADDR_W.

## Timing
- Reset (async): state=IDLE, last_grant=IF (so the first tie goes to MEM), and all outputs are 0: ram_a, ram_wr, ram_dout, if_done, if_data, mem_done, mem_rdata, busy. Reset mid-transaction aborts immediately; no done is issued afterwards.
- Grant is taken at edge E0, where IDLE samples req. ram_a=base is valid in the cycle after E0.
- Read of N bytes: done is high in the cycle after edge E0+N+1, i.e. N+1 busy cycles plus the DONE cycle. An IF fetch has done in cycle 6 after E0.
- Write of N bytes: ram_wr is high for exactly N consecutive cycles; done is high in the cycle after edge E0+N.
- Back-to-back: a request still high during DONE is granted at the edge that ends the IDLE cycle following DONE. The minimum gap is one IDLE cycle.
- ram_wr is never high in RD, DONE or IDLE.

## Test plan
- Reset, then IF req addr=0x100 with RAM[0x100..0x103]=11,22,33,44 → ram_a steps 0x100..0x103; if_done one cycle with if_data=0x44332211, 6 cycles after grant edge; mem_done stays 0.
- MEM store we=1, len=1, addr=0x20, wdata=0xAABBCCDD → ram_wr high for 2 cycles writing 0xDD@0x20 then 0xCC@0x21; mem_done pulses once; RAM[0x22] unchanged.
- MEM load len=0 addr=0x7 with RAM[7]=0xF0 → mem_rdata=0x000000F0 (zero-extended); done after 2 busy cycles.
- if_req and mem_req both held continuously from reset → grants alternate MEM, IF, MEM, IF; each done pulses exactly once per transaction; no double grant during DONE.
- IF read at addr=0xFFFFFFFE → ram_a sequence FFFFFFFE, FFFFFFFF, 0, 1.
- Assert rst in the middle of a 4-byte store → ram_wr drops to 0 asynchronously, busy=0, no mem_done; a reissued request then completes normally.
